// File: rtl/decoder_pkg.sv
// Shared definitions for the instruction decoder queue: opcode encodings,
// default field widths and the default decoded-word layout.
package decoder_pkg;

    // Default field widths; the decoder parameters default to these.
    localparam int unsigned DEC_OPCODE_W = 4;
    localparam int unsigned DEC_REG_W    = 14;
    localparam int unsigned DEC_DATA_W   = 32;
    localparam int unsigned DEC_SPRITE_W = 5;

    // Opcode encodings seen on dataA[OPCODE_W-1:0].
    localparam logic [3:0] OP_SET_POS       = 4'h0;
    localparam logic [3:0] OP_WR_SPRITE_MEM = 4'h1;
    localparam logic [3:0] OP_SET_BG        = 4'h3;
    localparam logic [3:0] OP_IDLE          = 4'hF;

    // Decoded word as stored in the FIFO, at the default widths.
    typedef struct packed {
        logic [DEC_OPCODE_W-1:0] opcode;
        logic [DEC_REG_W-1:0]    register;
        logic [DEC_DATA_W-1:0]   data;
    } decoded_word_t;

endpackage

// File: rtl/instr_decoder_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy level.
// Pushes while full and pops while empty are ignored. DEPTH must be a power
// of two so the pointers wrap naturally.
module sync_fifo
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Next pointer and level values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since the level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_decoder_queue.sv
// instr_decoder_queue: decodes host instruction words, filters illegal
// opcodes, buffers decoded words in a FIFO and presents them through a
// registered valid/ready output stage.
// Optional feature macro: DECODER_ERR_CNT_EN adds the err_count port and a
// saturating illegal-opcode counter.
module instr_decoder_queue
    import decoder_pkg::*;
#(
    parameter int unsigned OPCODE_W = DEC_OPCODE_W,
    parameter int unsigned REG_W    = DEC_REG_W,
    parameter int unsigned DATA_W   = DEC_DATA_W,
    parameter int unsigned SPRITE_W = DEC_SPRITE_W,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [31:0]              dataA,
    input  logic [DATA_W-1:0]        dataB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_W-1:0]      out_opcode,
    output logic [REG_W-1:0]         out_register,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [7:0]               err_count
`endif
);

    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WORD_W = OPCODE_W + REG_W + DATA_W;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    register;
        logic [DATA_W-1:0]   data;
    } word_t;

    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic             load;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_lvl;
    word_t            dec_word;
    word_t            head_word;
    word_t            out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             unused_dataa;

    assign unused_dataa = ^dataA;

    assign instr_ready = ~fifo_full;
    assign accept      = instr_valid & instr_ready;
    assign push        = accept & legal;

    // Field extraction by opcode; anything unlisted is flagged illegal.
    always_comb begin
        legal           = 1'b0;
        dec_word        = '0;
        dec_word.opcode = dataA[OPCODE_W-1:0];
        dec_word.data   = dataB;
        case (dataA[OPCODE_W-1:0])
            OPCODE_W'(OP_SET_POS): begin
                legal             = 1'b1;
                dec_word.register = REG_W'(dataA[4 +: SPRITE_W]);
            end
            OPCODE_W'(OP_WR_SPRITE_MEM): begin
                legal             = 1'b1;
                dec_word.register = dataA[4 +: REG_W];
            end
            OPCODE_W'(OP_SET_BG): begin
                legal             = 1'b1;
                dec_word.register = '0;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (dec_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    // The output register refills whenever it is empty or being consumed;
    // the FIFO is popped only when it actually has a word to hand over.
    assign load = ~out_valid_q | out_ready;
    assign pop  = load & ~fifo_empty;

    // Output stage and sticky overflow next-state.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q | (instr_valid & ~instr_ready);
        if (load) begin
            out_valid_d = ~fifo_empty;
            if (!fifo_empty) begin
                out_d = head_word;
            end
        end
    end

    // Output stage and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_opcode   = out_valid_q ? out_q.opcode : OPCODE_W'(OP_IDLE);
    assign out_register = out_q.register;
    assign out_data     = out_q.data;
    assign fifo_level   = fifo_lvl;
    assign overflow     = overflow_q;

`ifdef DECODER_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Illegal accepted opcodes, saturating at 255.
    always_comb begin
        err_d = err_q;
        if (accept && !legal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    // Illegal opcodes complete the handshake and are dropped without record.
`endif

endmodule

// File: tb/tb_instr_decoder_queue.sv
// Directed self-checking bench for instr_decoder_queue (DEPTH=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_decoder_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [13:0] out_register;
    logic [31:0] out_data;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef DECODER_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    instr_decoder_queue #(
        .OPCODE_W (4),
        .REG_W    (14),
        .DATA_W   (32),
        .SPRITE_W (5),
        .DEPTH    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .dataA        (dataA),
        .dataB        (dataB),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_register (out_register),
        .out_data     (out_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
`ifdef DECODER_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"},  64'(out_valid), 64'd0);
        chk({tag, ".opcode"}, 64'(out_opcode), 64'hF);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        dataA       = '0;
        dataB       = '0;
        out_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        chk_idle("rst");
        chk("rst.register", 64'(out_register), 64'd0);
        chk("rst.data",     64'(out_data), 64'd0);
        chk("rst.level",    64'(fifo_level), 64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);
        chk("rst.ready",    64'(instr_ready), 64'd1);
`ifdef DECODER_ERR_CNT_EN
        chk("rst.err", 64'(err_count), 64'd0);
`endif

        // SET_POS: two-cycle latency
        instr_valid = 1'b1;
        dataA       = 32'h0000_01A0;
        dataB       = 32'h0064_0032;
        step();
        instr_valid = 1'b0;
        chk("setpos.valid_n",  64'(out_valid), 64'd0);
        chk("setpos.level_n",  64'(fifo_level), 64'd1);
        step();
        chk("setpos.valid",    64'(out_valid), 64'd1);
        chk("setpos.opcode",   64'(out_opcode), 64'd0);
        chk("setpos.register", 64'(out_register), 64'h1A);
        chk("setpos.data",     64'(out_data), 64'h0064_0032);
        chk("setpos.level",    64'(fifo_level), 64'd0);
        out_ready = 1'b1;
        step();
        chk_idle("setpos.pop");
        out_ready = 1'b0;

        // WR_SPRITE_MEM held under backpressure
        instr_valid = 1'b1;
        dataA       = 32'h0003_FFF1;
        dataB       = 32'hCAFE_0001;
        step();
        instr_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wrsp.valid",    64'(out_valid), 64'd1);
            chk("wrsp.opcode",   64'(out_opcode), 64'd1);
            chk("wrsp.register", 64'(out_register), 64'h3FFF);
            chk("wrsp.data",     64'(out_data), 64'hCAFE_0001);
            step();
        end
        out_ready = 1'b1;
        step();
        chk_idle("wrsp.pop");
        out_ready = 1'b0;

        // Fill past capacity: 10 offered, 9 stored, overflow set
        for (int k = 0; k < 10; k++) begin
            instr_valid = 1'b1;
            dataA       = 32'((k + 1) << 4) | 32'h1;
            dataB       = 32'h1000 + 32'(k);
            chk("fill.ready", 64'(instr_ready), (k == 9) ? 64'd0 : 64'd1);
            step();
        end
        instr_valid = 1'b0;
        chk("fill.overflow", 64'(overflow), 64'd1);
        chk("fill.level",    64'(fifo_level), 64'd8);
        chk("fill.ready_n",  64'(instr_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk("drain.valid",    64'(out_valid), 64'd1);
            chk("drain.register", 64'(out_register), 64'(k + 1));
            chk("drain.data",     64'(out_data), 64'h1000 + 64'(k));
            step();
        end
        chk_idle("drain.end");
        chk("drain.level",    64'(fifo_level), 64'd0);
        chk("drain.overflow", 64'(overflow), 64'd1);

        // Illegal opcodes are filtered
        instr_valid = 1'b1;
        dataA       = 32'h0000_0017;
        dataB       = 32'hDEAD_0007;
        step();
        chk("ill7.level", 64'(fifo_level), 64'd0);
        chk("ill7.ready", 64'(instr_ready), 64'd1);
        dataA = 32'h0000_0022;
        dataB = 32'hDEAD_0002;
        step();
        chk("ill2.level", 64'(fifo_level), 64'd0);
        chk_idle("ill2");
        dataA = 32'h0000_0FF3;
        dataB = 32'hBBBB_0003;
        step();
        instr_valid = 1'b0;
        chk("bg.level", 64'(fifo_level), 64'd1);
        step();
        chk("bg.valid",    64'(out_valid), 64'd1);
        chk("bg.opcode",   64'(out_opcode), 64'd3);
        chk("bg.register", 64'(out_register), 64'd0);
        chk("bg.data",     64'(out_data), 64'hBBBB_0003);
`ifdef DECODER_ERR_CNT_EN
        chk("bg.err", 64'(err_count), 64'd2);
`endif
        step();
        chk_idle("bg.pop");

        // Continuous stream of 20 words, one per cycle
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                instr_valid = 1'b1;
                dataA       = 32'(i << 4) | 32'h1;
                dataB       = 32'h2000 + 32'(i);
            end else begin
                instr_valid = 1'b0;
            end
            step();
            if (i == 0 || i == 21) begin
                chk("stream.valid_n", 64'(out_valid), 64'd0);
            end else begin
                chk("stream.valid",    64'(out_valid), 64'd1);
                chk("stream.register", 64'(out_register), 64'(i - 1));
                chk("stream.data",     64'(out_data), 64'h2000 + 64'(i - 1));
            end
        end

        // Reset with 4 words queued flushes everything
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            instr_valid = 1'b1;
            dataA       = 32'h0000_0003;
            dataB       = 32'h3000 + 32'(k);
            step();
        end
        instr_valid = 1'b0;
        chk("q4.level",    64'(fifo_level), 64'd3);
        chk("q4.valid",    64'(out_valid), 64'd1);
        chk("q4.overflow", 64'(overflow), 64'd1);
        reset = 1'b1;
        step();
        chk_idle("flush");
        chk("flush.level",    64'(fifo_level), 64'd0);
        chk("flush.overflow", 64'(overflow), 64'd0);
        chk("flush.register", 64'(out_register), 64'd0);
        chk("flush.data",     64'(out_data), 64'd0);
        reset = 1'b0;
        step();
        chk_idle("post");
        chk("post.ready", 64'(instr_ready), 64'd1);
`ifdef DECODER_ERR_CNT_EN
        chk("post.err", 64'(err_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
